mem_port_arbiter: RTL
=====================

# mem_port_arbiter

Arbitrates a single-ported unified instruction/data RAM between the fetch stage (instruction reads) and the memory stage (loads and stores) of the 5-stage RV32 pipeline. It sequences each RAM access through a programmable number of wait states and returns one-cycle acknowledges to the requesters. It generates per-stage stall signals that the pipeline registers use to hold state, and keeps a saturating count of fetch-starvation cycles for performance analysis.

## Interface
- WAIT_STATES, 1, extra RAM cycles per access beyond the first; legal range 0..7.
- CNT_W, 16, width of the conflict counter.

- clk_i  in  1  clock; all logic is on the rising edge.
- reset_i  in  1  synchronous, active-high reset.
- if_req_i  in  1  fetch read request; held high until if_ack_o.
- if_addr_i  in  32  fetch byte address.
- if_rdata_o  out  32  fetched instruction word; valid in the if_ack_o cycle and held until the next fetch completes.
- if_ack_o  out  1  one-cycle fetch completion pulse.
- mem_req_i  in  1  memory-stage request; held high until mem_ack_o.
- mem_we_i  in  1  1 = store, 0 = load.
- mem_addr_i  in  32  data byte address.
- mem_wdata_i  in  32  store data.
- mem_wstrb_i  in  4  store byte enables.
- mem_rdata_o  out  32  load data; valid in the mem_ack_o cycle and held until the next load completes.
- mem_ack_o  out  1  one-cycle data completion pulse.
- ram_en_o  out  1  RAM access enable.
- ram_we_o  out  4  RAM byte write enables.
- ram_addr_o  out  32  RAM address.
- ram_wdata_o  out  32  RAM write data.
- ram_rdata_i  in  32  RAM read data, sampled in the last access cycle.
- stall_fetch_o  out  1  if_req_i & ~if_ack_o (combinational).
- stall_mem_o  out  1  mem_req_i & ~mem_ack_o (combinational).
- conflict_cnt_o  out  CNT_W  saturating count of cycles in which the fetch request waited behind a data access.

## Operation
- FSM states: IDLE, ACCESS, ACK.
  - A registered grant flag owner records which side holds the RAM: 0 = fetch, 1 = data.
  - A 3-bit down-counter wcnt times the access.
- IDLE:
  - If mem_req_i is high: owner <= 1. The data side has fixed priority because it is the older instruction.
  - Else if if_req_i is high: owner <= 0.
  - On a grant: latch address, wdata, we and wstrb; wcnt <= WAIT_STATES; go to ACCESS.
  - With no request: stay in IDLE.
- ACCESS:
  - ram_en_o = 1; ram_addr_o and ram_wdata_o come from the latches.
  - ram_we_o = latched wstrb if (owner = 1 and we = 1), else 4'b0000.
  - If wcnt != 0: decrement wcnt.
  - If wcnt = 0: capture ram_rdata_i into if_rdata_o or mem_rdata_o by owner (loads and fetches only), then go to ACK.
- ACK:
  - Pulse the owner's ack for exactly one cycle, then return to IDLE.
  - Requests are not sampled in ACK. The pipeline advances on the ack edge, so the request seen in the following IDLE cycle is the next one.
- Stores leave mem_rdata_o unchanged. A store with mem_wstrb_i = 0 still runs the full sequence and writes nothing.
- Conflict counter:
  - Increments when if_req_i = 1 and (state != IDLE with owner = 1, or state = IDLE with mem_req_i = 1).
  - Saturates at all ones and never wraps.
- The stall outputs depend only on the request inputs and the ack registers; they have no path from ram_rdata_i.

## Timing
- Latency from the request-sampled edge to the ack cycle is WAIT_STATES + 2 cycles.
- ram_en_o is high for exactly WAIT_STATES + 1 consecutive cycles per access.
- Throughput is one access per WAIT_STATES + 3 cycles. The minimum gap between accesses is one ACK cycle plus one IDLE cycle.
- If both requests are high in IDLE: the data access runs first. Fetch is granted in the IDLE cycle after the data ACK if if_req_i is still high.
- Requests rising during ACCESS or ACK are not lost; they are served from the next IDLE.
- Reset values: state = IDLE, ram_en_o = 0, ram_we_o = 0, ram_addr_o = 0, ram_wdata_o = 0, both acks = 0, both rdata outputs = 0, conflict_cnt_o = 0, owner = 0, wcnt = 0.
- Reset asserted mid-access:
  - The next cycle is IDLE with ram_en_o = 0.
  - No ack is issued for the aborted access.
  - A partially completed store is not retried.

## Test plan
- WAIT_STATES = 1; fetch only, if_addr_i = 0x100 held, RAM returns 0x00000013 -> ram_en_o high for 2 cycles; if_ack_o pulses 3 cycles after the sampling edge; if_rdata_o = 0x00000013; stall_fetch_o high until the ack cycle.
- Simultaneous if_req_i and mem_req_i (load 0x2000, RAM returns 0xDEADBEEF) -> data served first and mem_rdata_o = 0xDEADBEEF; fetch acked WAIT_STATES + 3 cycles later; conflict_cnt_o = 4 at the fetch grant (WAIT_STATES = 1).
- Store to 0x3000, wdata 0xA5A5A5A5, wstrb 4'b0011 -> ram_we_o = 4'b0011 only during ACCESS; mem_ack_o pulses once; mem_rdata_o unchanged.
- WAIT_STATES = 0; back-to-back fetches with the request held -> ram_en_o pulses 1 cycle in every 3; no dropped or duplicated acks over 10 accesses.
- Reset asserted in the second ACCESS cycle of a load -> next cycle ram_en_o = 0, no mem_ack_o, mem_rdata_o = 0; a new request after reset completes normally.
- Force the counter near its limit (CNT_W = 4) under a sustained conflict -> conflict_cnt_o saturates at 15 and does not wrap.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Single-ported RAM arbiter between the fetch stage and the memory stage.
// Sequences each access through programmable wait states and counts fetch starvation.
module mem_port_arbiter #(
  parameter int unsigned WAIT_STATES = 1,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             if_req_i,
  input  logic [31:0]      if_addr_i,
  output logic [31:0]      if_rdata_o,
  output logic             if_ack_o,
  input  logic             mem_req_i,
  input  logic             mem_we_i,
  input  logic [31:0]      mem_addr_i,
  input  logic [31:0]      mem_wdata_i,
  input  logic [3:0]       mem_wstrb_i,
  output logic [31:0]      mem_rdata_o,
  output logic             mem_ack_o,
  output logic             ram_en_o,
  output logic [3:0]       ram_we_o,
  output logic [31:0]      ram_addr_o,
  output logic [31:0]      ram_wdata_o,
  input  logic [31:0]      ram_rdata_i,
  output logic             stall_fetch_o,
  output logic             stall_mem_o,
  output logic [CNT_W-1:0] conflict_cnt_o
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    ACK    = 2'd2
  } state_e;

  localparam logic [2:0] WAIT_INIT = 3'(WAIT_STATES);

  state_e           state_r;
  logic             owner_r;
  logic [2:0]       wcnt_r;
  logic             we_r;
  logic [31:0]      addr_r;
  logic [31:0]      wdata_r;
  logic             ram_en_r;
  logic [3:0]       ram_we_r;
  logic             if_ack_r;
  logic             mem_ack_r;
  logic [31:0]      if_rdata_r;
  logic [31:0]      mem_rdata_r;
  logic [CNT_W-1:0] cnt_r;
  logic             conflict_s;
  logic             cnt_sat_s;

  // Access sequencer: grant, wait-state countdown, read capture and ack pulse
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_r     <= IDLE;
      owner_r     <= 1'b0;
      wcnt_r      <= 3'd0;
      we_r        <= 1'b0;
      addr_r      <= 32'h0000_0000;
      wdata_r     <= 32'h0000_0000;
      ram_en_r    <= 1'b0;
      ram_we_r    <= 4'b0000;
      if_ack_r    <= 1'b0;
      mem_ack_r   <= 1'b0;
      if_rdata_r  <= 32'h0000_0000;
      mem_rdata_r <= 32'h0000_0000;
    end else begin
      if_ack_r  <= 1'b0;
      mem_ack_r <= 1'b0;
      case (state_r)
        IDLE: begin
          // Data side wins ties: it belongs to the older instruction
          if (mem_req_i) begin
            owner_r  <= 1'b1;
            addr_r   <= mem_addr_i;
            wdata_r  <= mem_wdata_i;
            we_r     <= mem_we_i;
            ram_we_r <= mem_we_i ? mem_wstrb_i : 4'b0000;
            ram_en_r <= 1'b1;
            wcnt_r   <= WAIT_INIT;
            state_r  <= ACCESS;
          end else if (if_req_i) begin
            owner_r  <= 1'b0;
            addr_r   <= if_addr_i;
            wdata_r  <= 32'h0000_0000;
            we_r     <= 1'b0;
            ram_we_r <= 4'b0000;
            ram_en_r <= 1'b1;
            wcnt_r   <= WAIT_INIT;
            state_r  <= ACCESS;
          end else begin
            state_r <= IDLE;
          end
        end
        ACCESS: begin
          if (wcnt_r != 3'd0) begin
            wcnt_r <= wcnt_r - 3'd1;
          end else begin
            ram_en_r <= 1'b0;
            ram_we_r <= 4'b0000;
            state_r  <= ACK;
            if (owner_r) begin
              mem_ack_r <= 1'b1;
              if (!we_r) begin
                mem_rdata_r <= ram_rdata_i;
              end
            end else begin
              if_ack_r   <= 1'b1;
              if_rdata_r <= ram_rdata_i;
            end
          end
        end
        ACK: begin
          state_r <= IDLE;
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  // Fetch is starved when it waits on a data access that holds or is about to take the RAM
  assign conflict_s = if_req_i &
                      (((state_r != IDLE) & owner_r) | ((state_r == IDLE) & mem_req_i));
  assign cnt_sat_s  = &cnt_r;

  // Saturating fetch-starvation counter
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cnt_r <= '0;
    end else if (conflict_s && !cnt_sat_s) begin
      cnt_r <= cnt_r + CNT_W'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign if_rdata_o     = if_rdata_r;
  assign if_ack_o       = if_ack_r;
  assign mem_rdata_o    = mem_rdata_r;
  assign mem_ack_o      = mem_ack_r;
  assign ram_en_o       = ram_en_r;
  assign ram_we_o       = ram_we_r;
  assign ram_addr_o     = addr_r;
  assign ram_wdata_o    = wdata_r;
  assign stall_fetch_o  = if_req_i & ~if_ack_r;
  assign stall_mem_o    = mem_req_i & ~mem_ack_r;
  assign conflict_cnt_o = cnt_r;

endmodule
